// File: rtl/nfa_pkg.sv
// Shared definitions for the match-result collector.
// Holds the collector state encoding and the default widths used by
// result_collector (weight index, string id, statistics counters).
package nfa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int IDX_W_DEF = 16;
  localparam int STR_W_DEF = 8;
  localparam int CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/lowest_one_finder.sv
// Combinational lowest-set-bit locator.
// Ports:
//   bits     in   W-bit vector to scan
//   idx      out  position of the lowest set bit (0 when bits is zero)
//   found    out  at least one bit is set
//   one_hot  out  at most one bit is set (one-hot or all-zero)
module lowest_one_finder #(
  parameter int W  = 256,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  bits,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          one_hot
);

  // Scan from the top down so the last hit, i.e. the lowest bit, wins.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign found = |bits;

  // Clearing the lowest set bit leaves zero only for one-hot or zero input.
  assign one_hot = ((bits & (bits - W'(1))) == '0);

endmodule

// File: rtl/result_collector.sv
// Match-result collector.
// Accepts a snapshot of per-PE match bits and serialises it into one
// record per set bit, lowest bit first, each tagged with its weight index
// (batch base + bit position, wrapping) and the producing string id.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   snap_valid/snap_ready  snapshot handshake
//   snap_bits              per-PE match bits (bit k = group k/num, lane k%num)
//   snap_base, snap_str    weight index of PE 0 and string id of the batch
//   m_valid/m_ready        record handshake
//   m_idx, m_str, m_last   record payload; m_last marks final record of batch
//   busy                   collector is not idle
//   match_count            accepted records, saturating
//   batch_count            accepted snapshots, wrapping
module result_collector
  import nfa_pkg::*;
#(
  parameter int groups               = 16,
  parameter int num                  = 16,
  parameter int max_number_of_weight = num * groups,
  parameter int IDX_W                = IDX_W_DEF,
  parameter int STR_W                = STR_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            snap_valid,
  output logic                            snap_ready,
  input  logic [max_number_of_weight-1:0] snap_bits,
  input  logic [IDX_W-1:0]                snap_base,
  input  logic [STR_W-1:0]                snap_str,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [IDX_W-1:0]                m_idx,
  output logic [STR_W-1:0]                m_str,
  output logic                            m_last,
  output logic                            busy,
  output logic [CNT_W-1:0]                match_count,
  output logic [CNT_W-1:0]                batch_count
);

  localparam int W  = max_number_of_weight;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       pend_q;
  logic [IDX_W-1:0]   base_q;
  logic [STR_W-1:0]   str_q;
  logic [CNT_W-1:0]   match_count_q;
  logic [CNT_W-1:0]   batch_count_q;

  logic [IW-1:0]      low_idx;
  logic               low_found;
  logic               low_one_hot;
  logic               snap_hs;
  logic               rec_hs;
  logic               last_rec;

  lowest_one_finder #(
    .W  (W),
    .IW (IW)
  ) u_finder (
    .bits    (pend_q),
    .idx     (low_idx),
    .found   (low_found),
    .one_hot (low_one_hot)
  );

  assign last_rec = low_found && low_one_hot;
  assign snap_hs  = snap_valid && (state_q == IDLE);
  assign rec_hs   = m_ready && (state_q == EMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // An empty snapshot is counted but produces no records.
        if (snap_hs && (snap_bits != '0)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rec_hs && last_rec) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q        <= '0;
      base_q        <= '0;
      str_q         <= '0;
      match_count_q <= '0;
      batch_count_q <= '0;
    end else begin
      if (snap_hs) begin
        pend_q        <= snap_bits;
        base_q        <= snap_base;
        str_q         <= snap_str;
        batch_count_q <= batch_count_q + CNT_W'(1);
      end else if (rec_hs) begin
        // x & (x-1) drops exactly the lowest set bit.
        pend_q <= pend_q & (pend_q - W'(1));
        if (match_count_q != CNT_MAX) begin
          match_count_q <= match_count_q + CNT_W'(1);
        end
      end
    end
  end

  // Every output is a function of registered state only.
  assign snap_ready  = (state_q == IDLE);
  assign m_valid     = (state_q == EMIT);
  assign busy        = (state_q != IDLE);
  assign m_idx       = base_q + IDX_W'(low_idx);
  assign m_str       = str_q;
  assign m_last      = (state_q == EMIT) && last_rec;
  assign match_count = match_count_q;
  assign batch_count = batch_count_q;

endmodule
